// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory subsystem: cache-line type and arbiter FSM states.
package rv32i_types;

  localparam int LINE_OFFSET_W = 5;

  typedef logic [255:0] rv32i_line;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SERVE_I = 3'd1,
    SERVE_D = 3'd2,
    RESP_I  = 3'd3,
    RESP_D  = 3'd4
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (I-cache / D-cache) to single physical-memory port arbiter.
// One transaction at a time, round-robin on ties, registered one-cycle response.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no transaction; arbitrate between i_read and d_read/d_write
// SERVE_I | I-side line read in flight on pmem, waiting for pmem_resp
// SERVE_D | D-side line read or writeback in flight, waiting for pmem_resp
// RESP_I  | i_resp pulse, i_rdata holds the returned line
// RESP_D  | d_resp pulse, d_rdata updated on reads only
module mem_arbiter
  import rv32i_types::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic              i_resp,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_resp,
  output logic [LINE_W-1:0] d_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [LINE_W-1:0] pmem_rdata
);

  arb_state_t        state_q, state_d;
  grant_t            last_grant_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              write_q;
  logic [LINE_W-1:0] i_rdata_q, d_rdata_q;
  logic              i_req, d_req;
  logic              grant_i, grant_d;
  logic              serving;

  assign i_req   = i_read;
  assign d_req   = d_read | d_write;
  assign serving = (state_q == SERVE_I) || (state_q == SERVE_D);

  // Round-robin grant: a lone requester wins, on a tie the side not served last wins.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_q == IDLE) begin
      if (i_req && (!d_req || (last_grant_q == GRANT_D))) grant_i = 1'b1;
      else if (d_req)                                    grant_d = 1'b1;
    end
  end

  // Next-state logic; pmem_resp only matters while a transaction is in flight.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grant_i)      state_d = SERVE_I;
        else if (grant_d) state_d = SERVE_D;
      end
      SERVE_I: if (pmem_resp) state_d = RESP_I;
      SERVE_D: if (pmem_resp) state_d = RESP_D;
      RESP_I:  state_d = IDLE;
      RESP_D:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any transaction without issuing a response.
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Grant-time latches: requester inputs are not looked at again until IDLE.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_grant_q <= GRANT_D;
      addr_q       <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
    end else if (grant_i) begin
      last_grant_q <= GRANT_I;
      addr_q       <= {i_address[ADDR_W-1:LINE_OFFSET_W], {LINE_OFFSET_W{1'b0}}};
      write_q      <= 1'b0;
    end else if (grant_d) begin
      last_grant_q <= GRANT_D;
      addr_q       <= {d_address[ADDR_W-1:LINE_OFFSET_W], {LINE_OFFSET_W{1'b0}}};
      wdata_q      <= d_wdata;
      write_q      <= d_write;
    end
  end

  // Capture returned lines; each side keeps its last line until its next read completes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else if (pmem_resp) begin
      if (state_q == SERVE_I)                 i_rdata_q <= pmem_rdata;
      if ((state_q == SERVE_D) && !write_q)   d_rdata_q <= pmem_rdata;
    end
  end

  assign pmem_read    = serving && !write_q;
  assign pmem_write   = serving &&  write_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign i_resp       = (state_q == RESP_I);
  assign d_resp       = (state_q == RESP_D);
  assign i_rdata      = i_rdata_q;
  assign d_rdata      = d_rdata_q;

`ifndef SYNTHESIS
  // A D-side request with both ops set is resolved as a write, but it is a cache bug.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (!(d_read && d_write))
        else $error("mem_arbiter: d_read and d_write high together");
      assert (!(pmem_read && pmem_write))
        else $error("mem_arbiter: pmem_read and pmem_write high together");
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomised bench for mem_arbiter with a behavioural pmem responder.
module tb_mem_arbiter;
  import rv32i_types::*;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              i_read = 1'b0;
  logic [ADDR_W-1:0] i_address = '0;
  logic              i_resp;
  logic [LINE_W-1:0] i_rdata;
  logic              d_read = 1'b0;
  logic              d_write = 1'b0;
  logic [ADDR_W-1:0] d_address = '0;
  logic [LINE_W-1:0] d_wdata = '0;
  logic              d_resp;
  logic [LINE_W-1:0] d_rdata;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic              pmem_resp = 1'b0;
  logic [LINE_W-1:0] pmem_rdata = '0;

  int checks = 0;
  int failures = 0;

  int lat = 1;
  bit lat_rand = 1'b0;
  bit stray = 1'b0;

  rv32i_line pmem_mem [logic [31:0]];
  rv32i_line gold [logic [31:0]];

  bit done_i, done_d;

  mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_resp(d_resp), .d_rdata(d_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  always #5 clk = ~clk;

  function automatic rv32i_line pat(input logic [31:0] a);
    return {8{a ^ 32'hc0de_0000}};
  endfunction

  function automatic rv32i_line gold_rd(input logic [31:0] a);
    if (gold.exists(a)) return gold[a];
    return pat(a);
  endfunction

  // pmem model: responds after 'lat' active cycles, junk on rdata otherwise
  always begin : pmem_model
    int cnt;
    int cur_lat;
    cnt = 0;
    cur_lat = 1;
    forever begin
      @(posedge clk); #1;
      pmem_resp  = 1'b0;
      pmem_rdata = {8{$urandom}};
      if (pmem_read || pmem_write) begin
        if (cnt == 0) cur_lat = lat_rand ? int'($urandom_range(1, 20)) : lat;
        cnt++;
        if (cnt >= cur_lat) begin
          pmem_resp = 1'b1;
          if (pmem_write) pmem_mem[pmem_address] = pmem_wdata;
          else pmem_rdata = pmem_mem.exists(pmem_address) ? pmem_mem[pmem_address] : pat(pmem_address);
          cnt = 0;
        end
      end else begin
        cnt = 0;
        pmem_resp = stray;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    i_address = '0; d_address = '0; d_wdata = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    i_read = 1'b1; i_address = 32'h0000_0120;
    d_write = 1'b1; d_address = 32'h0000_0200; d_wdata = {32{8'h5A}};
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({i_resp, d_resp, pmem_read, pmem_write} !== 4'b0000)
      $display("FAIL reset_ctrl: got %b expected 0000", {i_resp, d_resp, pmem_read, pmem_write});
    checks++;
    if (pmem_address !== 32'h0) $display("FAIL reset_addr: got %h expected 0", pmem_address);
    checks++;
    if (pmem_wdata !== '0) $display("FAIL reset_wdata: got %h expected 0", pmem_wdata);
    checks++;
    if (i_rdata !== '0 || d_rdata !== '0) $display("FAIL reset_rdata: got %h/%h expected 0", i_rdata, d_rdata);
    if ({i_resp, d_resp, pmem_read, pmem_write} !== 4'b0000 || pmem_address !== 32'h0 ||
        pmem_wdata !== '0 || i_rdata !== '0 || d_rdata !== '0) failures++;
    i_read = 1'b0; d_write = 1'b0; d_wdata = '0;
    @(posedge clk); #1 reset_n = 1'b1;
    // pmem_resp while IDLE must be ignored
    stray = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (i_resp !== 1'b0 || d_resp !== 1'b0 || i_rdata !== '0 || d_rdata !== '0) begin
        failures++;
        $display("FAIL stray_resp c=%0d: got resp %b%b rdata %h/%h expected all 0", c, i_resp, d_resp, i_rdata, d_rdata);
      end
    end
    stray = 1'b0;
  endtask

  task automatic test_i_only();
    logic exp_pr;
    do_reset();
    lat = 5;
    i_address = 32'h0000_1044; i_read = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      exp_pr = (c >= 1 && c <= 5);
      checks++;
      if (pmem_read !== exp_pr || pmem_write !== 1'b0) begin
        failures++;
        $display("FAIL i_only_pmem c=%0d: got rd=%b wr=%b expected rd=%b wr=0", c, pmem_read, pmem_write, exp_pr);
      end
      if (exp_pr) begin
        checks++;
        if (pmem_address !== 32'h0000_1040) begin
          failures++;
          $display("FAIL i_only_addr c=%0d: got %h expected 00001040", c, pmem_address);
        end
      end
      checks++;
      if (i_resp !== (c == 6) || d_resp !== 1'b0) begin
        failures++;
        $display("FAIL i_only_resp c=%0d: got i=%b d=%b expected i=%b d=0", c, i_resp, d_resp, (c == 6));
      end
      if (c == 6) begin
        checks++;
        if (i_rdata !== pat(32'h0000_1040)) begin
          failures++;
          $display("FAIL i_only_data: got %h expected %h", i_rdata, pat(32'h0000_1040));
        end
        i_read = 1'b0;
      end
    end
    checks++;
    if (i_rdata !== pat(32'h0000_1040)) begin
      failures++;
      $display("FAIL i_only_hold: got %h expected %h", i_rdata, pat(32'h0000_1040));
    end
  endtask

  task automatic test_d_write();
    logic exp_pw;
    do_reset();
    lat = 3;
    d_address = 32'h8000_0020; d_wdata = {32{8'hA5}}; d_write = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      exp_pw = (c >= 1 && c <= 3);
      checks++;
      if (pmem_write !== exp_pw || pmem_read !== 1'b0) begin
        failures++;
        $display("FAIL d_write_pmem c=%0d: got wr=%b rd=%b expected wr=%b rd=0", c, pmem_write, pmem_read, exp_pw);
      end
      if (exp_pw) begin
        checks++;
        if (pmem_wdata !== {32{8'hA5}} || pmem_address !== 32'h8000_0020) begin
          failures++;
          $display("FAIL d_write_latch c=%0d: got %h @%h expected a5.. @80000020", c, pmem_wdata, pmem_address);
        end
      end
      checks++;
      if (d_resp !== (c == 4) || i_resp !== 1'b0) begin
        failures++;
        $display("FAIL d_write_resp c=%0d: got d=%b i=%b expected d=%b i=0", c, d_resp, i_resp, (c == 4));
      end
      if (c == 4) begin
        checks++;
        if (d_rdata !== '0) begin
          failures++;
          $display("FAIL d_write_rdata: got %h expected 0 (unchanged)", d_rdata);
        end
        d_write = 1'b0;
      end
    end
  endtask

  task automatic test_round_robin();
    int n;
    do_reset();
    lat = 2;
    n = 0;
    i_address = 32'h0000_3010; d_address = 32'h8000_0020;
    i_read = 1'b1; d_read = 1'b1;
    for (int c = 0; c < 40 && n < 8; c++) begin
      @(negedge clk);
      if (i_resp || d_resp) begin
        checks++;
        if (c != 3 + 4 * n) begin
          failures++;
          $display("FAIL rr_timing n=%0d: got cycle %0d expected %0d", n, c, 3 + 4 * n);
        end
        checks++;
        if (i_resp !== (n % 2 == 0) || d_resp !== (n % 2 == 1)) begin
          failures++;
          $display("FAIL rr_order n=%0d: got i=%b d=%b expected i=%b d=%b", n, i_resp, d_resp, (n % 2 == 0), (n % 2 == 1));
        end
        checks++;
        if (i_resp && i_rdata !== pat(32'h0000_3000)) begin
          failures++;
          $display("FAIL rr_idata n=%0d: got %h expected %h", n, i_rdata, pat(32'h0000_3000));
        end else if (d_resp && d_rdata !== {32{8'hA5}}) begin
          failures++;
          $display("FAIL rr_ddata n=%0d: got %h expected a5..", n, d_rdata);
        end
        n++;
      end
    end
    checks++;
    if (n != 8) begin
      failures++;
      $display("FAIL rr_count: got %0d responses expected 8", n);
    end
    i_read = 1'b0; d_read = 1'b0;
  endtask

  task automatic test_mid_change();
    logic exp_pr, exp_pw;
    do_reset();
    lat = 4;
    i_address = 32'h0000_1044; i_read = 1'b1;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      exp_pr = (c >= 1 && c <= 4);
      exp_pw = (c >= 7 && c <= 10);
      checks++;
      if (pmem_read !== exp_pr || pmem_write !== exp_pw) begin
        failures++;
        $display("FAIL mid_pmem c=%0d: got rd=%b wr=%b expected rd=%b wr=%b", c, pmem_read, pmem_write, exp_pr, exp_pw);
      end
      if (exp_pr) begin
        checks++;
        if (pmem_address !== 32'h0000_1040) begin
          failures++;
          $display("FAIL mid_addr_i c=%0d: got %h expected 00001040", c, pmem_address);
        end
      end
      if (exp_pw) begin
        checks++;
        if (pmem_address !== 32'h0000_4000 || pmem_wdata !== {32{8'h3C}}) begin
          failures++;
          $display("FAIL mid_addr_d c=%0d: got %h @%h expected 3c.. @00004000", c, pmem_wdata, pmem_address);
        end
      end
      checks++;
      if (i_resp !== (c == 5) || d_resp !== (c == 11)) begin
        failures++;
        $display("FAIL mid_resp c=%0d: got i=%b d=%b expected i=%b d=%b", c, i_resp, d_resp, (c == 5), (c == 11));
      end
      if (c == 2) begin
        i_address = 32'h0000_2000;
        d_address = 32'h0000_4000; d_wdata = {32{8'h3C}}; d_write = 1'b1;
      end
      if (c == 5) begin
        checks++;
        if (i_rdata !== pat(32'h0000_1040)) begin
          failures++;
          $display("FAIL mid_idata: got %h expected %h", i_rdata, pat(32'h0000_1040));
        end
        i_read = 1'b0;
      end
      if (c == 11) d_write = 1'b0;
    end
  endtask

  task automatic test_reset_abort();
    do_reset();
    lat = 10;
    d_address = 32'h0000_5000; d_read = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c >= 1 && c <= 3) begin
        checks++;
        if (pmem_read !== 1'b1) begin
          failures++;
          $display("FAIL abort_pre c=%0d: got pmem_read=%b expected 1", c, pmem_read);
        end
      end
      if (c >= 4) begin
        checks++;
        if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || d_resp !== 1'b0 || i_resp !== 1'b0) begin
          failures++;
          $display("FAIL abort_post c=%0d: got rd=%b wr=%b d=%b i=%b expected 0000", c, pmem_read, pmem_write, d_resp, i_resp);
        end
      end
      if (c == 3) begin reset_n = 1'b0; d_read = 1'b0; end
      if (c == 4) reset_n = 1'b1;
    end
    lat = 2;
    @(posedge clk); #1;
    d_read = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (d_resp !== (c == 3)) begin
        failures++;
        $display("FAIL abort_retry c=%0d: got d_resp=%b expected %b", c, d_resp, (c == 3));
      end
      if (c == 3) begin
        checks++;
        if (d_rdata !== pat(32'h0000_5000)) begin
          failures++;
          $display("FAIL abort_retry_data: got %h expected %h", d_rdata, pat(32'h0000_5000));
        end
        d_read = 1'b0;
      end
    end
  endtask

  task automatic test_soak();
    do_reset();
    lat_rand = 1'b1;
    done_i = 1'b0;
    done_d = 1'b0;
    fork
      begin : side_i
        for (int t = 0; t < 30; t++) begin
          logic [31:0] a;
          int gap, others;
          bit got;
          gap = $urandom_range(0, 3);
          repeat (gap) begin
            @(negedge clk);
            checks++;
            if (i_resp !== 1'b0) begin failures++; $display("FAIL soak_i_spurious t=%0d: got i_resp=1 expected 0", t); end
          end
          @(posedge clk); #1;
          a = 32'h0001_0000 + ($urandom_range(0, 7) << 5) + $urandom_range(0, 31);
          i_address = a; i_read = 1'b1;
          got = 1'b0; others = 0;
          for (int w = 0; w < 60 && !got; w++) begin
            @(negedge clk);
            if (i_resp) got = 1'b1;
            else if (d_resp) others++;
          end
          i_read = 1'b0;
          checks++;
          if (!got) begin
            failures++;
            $display("FAIL soak_i_timeout t=%0d: got no i_resp expected one within 60 cycles", t);
          end else if (i_rdata !== gold_rd(a & ~32'h1f)) begin
            failures++;
            $display("FAIL soak_i_data t=%0d: got %h expected %h", t, i_rdata, gold_rd(a & ~32'h1f));
          end
          checks++;
          if (others > 1) begin failures++; $display("FAIL soak_i_starve t=%0d: got %0d D grants expected <=1", t, others); end
          @(negedge clk);
          checks++;
          if (i_resp !== 1'b0) begin failures++; $display("FAIL soak_i_dup t=%0d: got second i_resp expected 0", t); end
        end
        done_i = 1'b1;
      end
      begin : side_d
        rv32i_line last_rd;
        last_rd = '0;
        for (int t = 0; t < 30; t++) begin
          logic [31:0] a;
          rv32i_line wd;
          int gap, others;
          bit got, wr;
          gap = $urandom_range(0, 3);
          repeat (gap) begin
            @(negedge clk);
            checks++;
            if (d_resp !== 1'b0) begin failures++; $display("FAIL soak_d_spurious t=%0d: got d_resp=1 expected 0", t); end
          end
          @(posedge clk); #1;
          a = 32'h0001_0000 + ($urandom_range(0, 7) << 5) + $urandom_range(0, 31);
          wr = $urandom_range(0, 1) == 1;
          wd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
          d_address = a; d_wdata = wd;
          if (wr) d_write = 1'b1; else d_read = 1'b1;
          got = 1'b0; others = 0;
          for (int w = 0; w < 60 && !got; w++) begin
            @(negedge clk);
            if (d_resp) got = 1'b1;
            else if (i_resp) others++;
          end
          d_read = 1'b0; d_write = 1'b0;
          checks++;
          if (!got) begin
            failures++;
            $display("FAIL soak_d_timeout t=%0d: got no d_resp expected one within 60 cycles", t);
          end else if (wr) begin
            gold[a & ~32'h1f] = wd;
            if (d_rdata !== last_rd) begin
              failures++;
              $display("FAIL soak_d_wr_rdata t=%0d: got %h expected %h", t, d_rdata, last_rd);
            end
          end else begin
            last_rd = gold_rd(a & ~32'h1f);
            if (d_rdata !== last_rd) begin
              failures++;
              $display("FAIL soak_d_data t=%0d: got %h expected %h", t, d_rdata, last_rd);
            end
          end
          checks++;
          if (others > 1) begin failures++; $display("FAIL soak_d_starve t=%0d: got %0d I grants expected <=1", t, others); end
          @(negedge clk);
          checks++;
          if (d_resp !== 1'b0) begin failures++; $display("FAIL soak_d_dup t=%0d: got second d_resp expected 0", t); end
        end
        done_d = 1'b1;
      end
      begin : monitor
        while (!(done_i && done_d)) begin
          @(negedge clk);
          checks++;
          if (pmem_read && pmem_write) begin failures++; $display("FAIL soak_pmem_excl: got rd=1 wr=1 expected not both"); end
          checks++;
          if (i_resp && d_resp) begin failures++; $display("FAIL soak_resp_excl: got i=1 d=1 expected not both"); end
        end
      end
    join
    lat_rand = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_i_only();
    test_d_write();
    test_round_robin();
    test_mid_change();
    test_reset_abort();
    test_soak();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
